// File: rtl/memory_stage.sv
// Memory stage: issues loads/stores over a valid/ready channel, aligns load data, emits a one-cycle writeback pulse.
// Optional build macro MEMORY_MISALIGN_CHECK_EN adds misaligned-access trapping and the memory_misalign_v port.
module memory_stage #(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              execute_memory_v,
  output logic              memory_execute_ready,
  input  logic              execute_memory_load,
  input  logic              execute_memory_store,
  input  logic [2:0]        execute_memory_funct3,
  input  logic [WORD_W-1:0] execute_memory_result,
  input  logic [WORD_W-1:0] execute_memory_store_data,
  input  logic [REG_W-1:0]  execute_memory_rd,
  input  logic              execute_memory_rd_w_v,
  output logic              dmem_req_v,
  input  logic              dmem_req_ready,
  output logic              dmem_req_we,
  output logic [WORD_W-1:0] dmem_req_addr,
  output logic [WORD_W-1:0] dmem_req_wdata,
  output logic [3:0]        dmem_req_wmask,
  input  logic              dmem_resp_v,
  input  logic [WORD_W-1:0] dmem_resp_data,
`ifdef MEMORY_MISALIGN_CHECK_EN
  output logic              memory_misalign_v,
`endif
  output logic              memory_writeback_v,
  output logic              memory_writeback_rd_w_v,
  output logic [REG_W-1:0]  memory_writeback_rd,
  output logic [WORD_W-1:0] memory_writeback_rd_data
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t             state;
  logic [2:0]         funct3_p1;
  logic [1:0]         off_p1;
  logic [REG_W-1:0]   rd_p1;
  logic               rd_w_v_p1;

  logic               is_mem;
  logic [1:0]         off_in;
  logic               rd_w_v_in;

  function automatic logic [WORD_W-1:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                      input logic [WORD_W-1:0] w);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{(WORD_W-8){b[7]}}, b};
      3'b100:  return {{(WORD_W-8){1'b0}}, b};
      3'b001:  return {{(WORD_W-16){h[15]}}, h};
      3'b101:  return {{(WORD_W-16){1'b0}}, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [WORD_W-1:0] store_wdata(input logic [2:0] f3, input logic [WORD_W-1:0] d);
    case (f3)
      3'b000:  return {4{d[7:0]}};
      3'b001:  return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] store_wmask(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000:  return 4'b0001 << off;
      3'b001:  return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

`ifdef MEMORY_MISALIGN_CHECK_EN
  // Halfwords need an even offset; word-sized (and wider encodings) need full alignment.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    if (f3[1])      return off != 2'd0;
    else if (f3[0]) return off[0];
    else            return 1'b0;
  endfunction
`endif

  assign is_mem               = execute_memory_load | execute_memory_store;
  assign off_in               = execute_memory_result[1:0];
  assign rd_w_v_in            = execute_memory_rd_w_v && (execute_memory_rd != '0);
  assign memory_execute_ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                    <= IDLE;
      funct3_p1                <= '0;
      off_p1                   <= '0;
      rd_p1                    <= '0;
      rd_w_v_p1                <= 1'b0;
      dmem_req_v               <= 1'b0;
      dmem_req_we              <= 1'b0;
      dmem_req_addr            <= '0;
      dmem_req_wdata           <= '0;
      dmem_req_wmask           <= '0;
      memory_writeback_v       <= 1'b0;
      memory_writeback_rd_w_v  <= 1'b0;
      memory_writeback_rd      <= '0;
      memory_writeback_rd_data <= '0;
`ifdef MEMORY_MISALIGN_CHECK_EN
      memory_misalign_v        <= 1'b0;
`endif
    end else begin
      memory_writeback_v <= 1'b0;
`ifdef MEMORY_MISALIGN_CHECK_EN
      memory_misalign_v  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (execute_memory_v) begin
            if (!is_mem) begin
              memory_writeback_v       <= 1'b1;
              memory_writeback_rd_w_v  <= rd_w_v_in;
              memory_writeback_rd      <= execute_memory_rd;
              memory_writeback_rd_data <= execute_memory_result;
`ifdef MEMORY_MISALIGN_CHECK_EN
            end else if (misaligned(execute_memory_funct3, off_in)) begin
              memory_writeback_v       <= 1'b1;
              memory_writeback_rd_w_v  <= 1'b0;
              memory_writeback_rd      <= execute_memory_rd;
              memory_writeback_rd_data <= '0;
              memory_misalign_v        <= 1'b1;
`endif
            end else begin
              // Store wins when both load and store are flagged.
              funct3_p1      <= execute_memory_funct3;
              off_p1         <= off_in;
              rd_p1          <= execute_memory_rd;
              rd_w_v_p1      <= rd_w_v_in && !execute_memory_store;
              dmem_req_v     <= 1'b1;
              dmem_req_we    <= execute_memory_store;
              dmem_req_addr  <= {execute_memory_result[WORD_W-1:2], 2'b00};
              dmem_req_wdata <= store_wdata(execute_memory_funct3, execute_memory_store_data);
              dmem_req_wmask <= execute_memory_store ?
                                store_wmask(execute_memory_funct3, off_in) : 4'b0000;
              state          <= REQ;
            end
          end
        end
        REQ: begin
          if (dmem_req_ready) begin
            dmem_req_v <= 1'b0;
            if (dmem_req_we) begin
              memory_writeback_v       <= 1'b1;
              memory_writeback_rd_w_v  <= 1'b0;
              memory_writeback_rd      <= rd_p1;
              memory_writeback_rd_data <= '0;
              state                    <= IDLE;
            end else begin
              state <= RESP;
            end
          end
        end
        RESP: begin
          if (dmem_resp_v) begin
            memory_writeback_v       <= 1'b1;
            memory_writeback_rd_w_v  <= rd_w_v_p1;
            memory_writeback_rd      <= rd_p1;
            memory_writeback_rd_data <= load_extract(funct3_p1, off_p1, dmem_resp_data);
            state                    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: expected writebacks queued at issue, popped when the pulse appears.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        execute_memory_v;
  logic        memory_execute_ready;
  logic        execute_memory_load;
  logic        execute_memory_store;
  logic [2:0]  execute_memory_funct3;
  logic [31:0] execute_memory_result;
  logic [31:0] execute_memory_store_data;
  logic [4:0]  execute_memory_rd;
  logic        execute_memory_rd_w_v;
  logic        dmem_req_v;
  logic        dmem_req_ready;
  logic        dmem_req_we;
  logic [31:0] dmem_req_addr;
  logic [31:0] dmem_req_wdata;
  logic [3:0]  dmem_req_wmask;
  logic        dmem_resp_v;
  logic [31:0] dmem_resp_data;
  logic        memory_writeback_v;
  logic        memory_writeback_rd_w_v;
  logic [4:0]  memory_writeback_rd;
  logic [31:0] memory_writeback_rd_data;
`ifdef MEMORY_MISALIGN_CHECK_EN
  logic        memory_misalign_v;
`endif

  typedef struct {
    logic        w;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        mis;
  } wb_t;

  wb_t sb[$];
  wb_t mon_e;
  int  vectors = 0;
  int  miscompares = 0;

  memory_stage dut (
    .clk                       (clk),
    .rst                       (rst),
    .execute_memory_v          (execute_memory_v),
    .memory_execute_ready      (memory_execute_ready),
    .execute_memory_load       (execute_memory_load),
    .execute_memory_store      (execute_memory_store),
    .execute_memory_funct3     (execute_memory_funct3),
    .execute_memory_result     (execute_memory_result),
    .execute_memory_store_data (execute_memory_store_data),
    .execute_memory_rd         (execute_memory_rd),
    .execute_memory_rd_w_v     (execute_memory_rd_w_v),
    .dmem_req_v                (dmem_req_v),
    .dmem_req_ready            (dmem_req_ready),
    .dmem_req_we               (dmem_req_we),
    .dmem_req_addr             (dmem_req_addr),
    .dmem_req_wdata            (dmem_req_wdata),
    .dmem_req_wmask            (dmem_req_wmask),
    .dmem_resp_v               (dmem_resp_v),
    .dmem_resp_data            (dmem_resp_data),
`ifdef MEMORY_MISALIGN_CHECK_EN
    .memory_misalign_v         (memory_misalign_v),
`endif
    .memory_writeback_v        (memory_writeback_v),
    .memory_writeback_rd_w_v   (memory_writeback_rd_w_v),
    .memory_writeback_rd       (memory_writeback_rd),
    .memory_writeback_rd_data  (memory_writeback_rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Writeback monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst && memory_writeback_v) begin
      if (sb.size() == 0) begin
        check("wb_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("wb_rd_w_v", {31'd0, memory_writeback_rd_w_v}, {31'd0, mon_e.w});
        check("wb_rd", {27'd0, memory_writeback_rd}, {27'd0, mon_e.rd});
        if (mon_e.w) check("wb_data", memory_writeback_rd_data, mon_e.data);
`ifdef MEMORY_MISALIGN_CHECK_EN
        check("wb_misalign", {31'd0, memory_misalign_v}, {31'd0, mon_e.mis});
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_instr(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] sdata, input logic [4:0] rd, input logic rdwv);
    execute_memory_v          = 1'b1;
    execute_memory_load       = ld;
    execute_memory_store      = st;
    execute_memory_funct3     = f3;
    execute_memory_result     = addr;
    execute_memory_store_data = sdata;
    execute_memory_rd         = rd;
    execute_memory_rd_w_v     = rdwv;
  endtask

  task automatic idle_instr();
    execute_memory_v     = 1'b0;
    execute_memory_load  = 1'b0;
    execute_memory_store = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_v"}, {31'd0, dmem_req_v}, 32'd0);
    check({tag, "_we"}, {31'd0, dmem_req_we}, 32'd0);
    check({tag, "_addr"}, dmem_req_addr, 32'd0);
    check({tag, "_wdata"}, dmem_req_wdata, 32'd0);
    check({tag, "_wmask"}, {28'd0, dmem_req_wmask}, 32'd0);
    check({tag, "_wb_v"}, {31'd0, memory_writeback_v}, 32'd0);
    check({tag, "_wb_w"}, {31'd0, memory_writeback_rd_w_v}, 32'd0);
    check({tag, "_wb_rd"}, {27'd0, memory_writeback_rd}, 32'd0);
    check({tag, "_wb_data"}, memory_writeback_rd_data, 32'd0);
`ifdef MEMORY_MISALIGN_CHECK_EN
    check({tag, "_mis"}, {31'd0, memory_misalign_v}, 32'd0);
`endif
    check({tag, "_ready"}, {31'd0, memory_execute_ready}, 32'd1);
  endtask

  // Issue a load and take it through the request handshake; leaves the DUT in RESP.
  task automatic ld_to_resp(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                            input int req_wait);
    check("ld_ready_in", {31'd0, memory_execute_ready}, 32'd1);
    drive_instr(1'b1, 1'b0, f3, addr, 32'h0, rd, 1'b1);
    step();
    idle_instr();
    for (int i = 0; i < req_wait; i++) begin
      check("ld_req_v_hold", {31'd0, dmem_req_v}, 32'd1);
      check("ld_addr_hold", dmem_req_addr, addr & 32'hFFFF_FFFC);
      check("ld_ready_busy", {31'd0, memory_execute_ready}, 32'd0);
      step();
    end
    check("ld_req_v", {31'd0, dmem_req_v}, 32'd1);
    check("ld_we", {31'd0, dmem_req_we}, 32'd0);
    check("ld_addr", dmem_req_addr, addr & 32'hFFFF_FFFC);
    dmem_req_ready = 1'b1;
    dmem_resp_v    = 1'b1;
    dmem_resp_data = 32'h5555_5555;
    step();
    dmem_req_ready = 1'b0;
    dmem_resp_v    = 1'b0;
    check("ld_req_drop", {31'd0, dmem_req_v}, 32'd0);
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                         input logic [31:0] resp, input logic [31:0] exp_data,
                         input int req_wait, input int resp_wait);
    sb.push_back('{w: (rd != 5'd0), rd: rd, data: exp_data, mis: 1'b0});
    ld_to_resp(f3, addr, rd, req_wait);
    for (int i = 0; i < resp_wait; i++) begin
      check("ld_wait_ready", {31'd0, memory_execute_ready}, 32'd0);
      step();
    end
    dmem_resp_v    = 1'b1;
    dmem_resp_data = resp;
    step();
    dmem_resp_v = 1'b0;
    check("ld_wb_pulse", {31'd0, memory_writeback_v}, 32'd1);
    check("ld_ready_back", {31'd0, memory_execute_ready}, 32'd1);
  endtask

  task automatic do_store(input logic both, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [4:0] rd,
                          input logic [31:0] exp_wdata, input logic [3:0] exp_mask, input int req_wait);
    sb.push_back('{w: 1'b0, rd: rd, data: 32'h0, mis: 1'b0});
    drive_instr(both, 1'b1, f3, addr, sdata, rd, 1'b1);
    step();
    idle_instr();
    for (int i = 0; i <= req_wait; i++) begin
      check("st_req_v", {31'd0, dmem_req_v}, 32'd1);
      check("st_we", {31'd0, dmem_req_we}, 32'd1);
      check("st_addr", dmem_req_addr, addr & 32'hFFFF_FFFC);
      check("st_wdata", dmem_req_wdata, exp_wdata);
      check("st_wmask", {28'd0, dmem_req_wmask}, {28'd0, exp_mask});
      check("st_ready_busy", {31'd0, memory_execute_ready}, 32'd0);
      if (i == req_wait) dmem_req_ready = 1'b1;
      step();
    end
    dmem_req_ready = 1'b0;
    check("st_req_drop", {31'd0, dmem_req_v}, 32'd0);
    check("st_wb_pulse", {31'd0, memory_writeback_v}, 32'd1);
    check("st_ready_back", {31'd0, memory_execute_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    idle_instr();
    execute_memory_funct3     = 3'd0;
    execute_memory_result     = 32'd0;
    execute_memory_store_data = 32'd0;
    execute_memory_rd         = 5'd0;
    execute_memory_rd_w_v     = 1'b0;
    dmem_req_ready            = 1'b0;
    dmem_resp_v               = 1'b0;
    dmem_resp_data            = 32'd0;
    #1;
    check_all_zero("rst");
    step();
    step();
    rst = 1'b0;

    // Back-to-back ALU ops.
    for (int i = 0; i < 3; i++) begin
      check("alu_ready", {31'd0, memory_execute_ready}, 32'd1);
      drive_instr(1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'h0, 5'd5, 1'b1);
      sb.push_back('{w: 1'b1, rd: 5'd5, data: 32'h1234_5678, mis: 1'b0});
      step();
    end
    idle_instr();
    check("alu_ready_end", {31'd0, memory_execute_ready}, 32'd1);
    step();
    check("alu_sb_drain", sb.size(), 32'd0);
    // ALU op with rd_w_v but rd=0 is suppressed.
    drive_instr(1'b0, 1'b0, 3'b000, 32'hCAFE_0001, 32'h0, 5'd0, 1'b1);
    sb.push_back('{w: 1'b0, rd: 5'd0, data: 32'h0, mis: 1'b0});
    step();
    idle_instr();
    step();

    // Loads of each size and sign.
    do_load(3'b000, 32'h0000_0103, 5'd3, 32'h80FF_0000, 32'hFFFF_FF80, 0, 0);
    do_load(3'b100, 32'h0000_0103, 5'd3, 32'h80FF_0000, 32'h0000_0080, 1, 0);
    do_load(3'b000, 32'h0000_0101, 5'd4, 32'h1234_7F56, 32'h0000_007F, 0, 1);
    do_load(3'b001, 32'h0000_0102, 5'd6, 32'h80FF_0000, 32'hFFFF_80FF, 0, 2);
    do_load(3'b101, 32'h0000_0102, 5'd6, 32'h80FF_0000, 32'h0000_80FF, 2, 0);
    do_load(3'b001, 32'h0000_0100, 5'd7, 32'h0000_9abc, 32'hFFFF_9ABC, 0, 0);
    do_load(3'b010, 32'h0000_0104, 5'd8, 32'h80FF_0000, 32'h80FF_0000, 0, 0);

    // Stores; the last one has load and store both asserted.
    do_store(1'b0, 3'b001, 32'h0000_0202, 32'hAAAA_BEEF, 5'd9, 32'hBEEF_BEEF, 4'b1100, 3);
    do_store(1'b0, 3'b000, 32'h0000_0201, 32'h1234_56EF, 5'd9, 32'hEFEF_EFEF, 4'b0010, 0);
    do_store(1'b0, 3'b001, 32'h0000_0200, 32'h0000_1357, 5'd9, 32'h1357_1357, 4'b0011, 1);
    do_store(1'b1, 3'b010, 32'h0000_0200, 32'h0BAD_F00D, 5'd9, 32'h0BAD_F00D, 4'b1111, 0);

    // Load to x0 with a slow response.
    do_load(3'b010, 32'h0000_0300, 5'd0, 32'hDEAD_BEEF, 32'h0, 0, 5);
    step();
    check("x0_sb_drain", sb.size(), 32'd0);

    // Reset while waiting for a response; the late response must be ignored.
    ld_to_resp(3'b010, 32'h0000_0400, 5'd10, 0);
    step();
    rst = 1'b1;
    #1;
    check_all_zero("rst_resp");
    step();
    rst = 1'b0;
    dmem_resp_v    = 1'b1;
    dmem_resp_data = 32'h1111_1111;
    step();
    dmem_resp_v = 1'b0;
    check("rst_ignored_wb", {31'd0, memory_writeback_v}, 32'd0);
    check("rst_ignored_req", {31'd0, dmem_req_v}, 32'd0);
    drive_instr(1'b0, 1'b0, 3'b000, 32'h0000_0042, 32'h0, 5'd11, 1'b1);
    sb.push_back('{w: 1'b1, rd: 5'd11, data: 32'h0000_0042, mis: 1'b0});
    step();
    idle_instr();
    check("post_rst_wb", {31'd0, memory_writeback_v}, 32'd1);
    step();

    // Misaligned word load.
`ifdef MEMORY_MISALIGN_CHECK_EN
    drive_instr(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 5'd12, 1'b1);
    sb.push_back('{w: 1'b0, rd: 5'd12, data: 32'h0, mis: 1'b1});
    step();
    idle_instr();
    check("mis_no_req", {31'd0, dmem_req_v}, 32'd0);
    check("mis_ready", {31'd0, memory_execute_ready}, 32'd1);
    check("mis_pulse", {31'd0, memory_misalign_v}, 32'd1);
    step();
    check("mis_pulse_end", {31'd0, memory_misalign_v}, 32'd0);
`else
    do_load(3'b010, 32'h0000_0101, 5'd12, 32'h0102_0304, 32'h0102_0304, 0, 0);
`endif

    step();
    step();
    check("final_sb_drain", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
